// File: rtl/vga_dbg_pkg.sv
// Shared types and sizing constants for the VGA debug-screen register shadow.
package vga_dbg_pkg;
  localparam int DBG_REG_N  = 32;
  localparam int DBG_ADDR_W = 5;
  localparam int DBG_DATA_W = 32;

  typedef enum logic {ST_IDLE, ST_COPY} state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// One-flop assertion-edge detector for a sync strobe of configurable polarity.
module vga_sync_edge #(
  parameter int POL = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic sig,
  output logic trig
);
  localparam logic ACT = (POL != 0);

  logic sig_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sig_q <= ~ACT;
    else         sig_q <= sig;
  end

  assign trig = (sig == ACT) && (sig_q != ACT);
endmodule

// File: rtl/vga_reg_shadow.sv
// Frame-synchronous shadow of the CPU register file for the VGA debug screen:
// a live bank follows CPU writes, and a display bank is refreshed at each vsync.
module vga_reg_shadow
  import vga_dbg_pkg::*;
#(
  parameter int REG_N     = DBG_REG_N,
  parameter int ADDR_W    = DBG_ADDR_W,
  parameter int DATA_W    = DBG_DATA_W,
  parameter int ZERO_REG  = 1,
  parameter int VSYNC_POL = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_wa,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              vsync,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] regAddr,
  output logic [DATA_W-1:0] regData,
  output logic              busy,
  output logic [15:0]       frame_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_N - 1);

  logic [DATA_W-1:0] live    [REG_N];
  logic [DATA_W-1:0] display [REG_N];
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       cnt_r;
  logic              trig;
  logic              wr_ok;
  logic [DATA_W-1:0] src;

  vga_sync_edge #(.POL(VSYNC_POL)) u_vs_edge (
    .clk    (clk),
    .resetn (resetn),
    .sig    (vsync),
    .trig   (trig)
  );

  assign wr_ok = cpu_we && !((ZERO_REG != 0) && (cpu_wa == '0));

  // Forward a same-cycle write to the register being copied so it is not lost.
  assign src = (wr_ok && (cpu_wa == idx)) ? cpu_wd : live[idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_N; i++) live[i] <= '0;
    end else if (wr_ok) begin
      live[cpu_wa] <= cpu_wd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      cnt_r <= '0;
      for (int i = 0; i < REG_N; i++) display[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig && !freeze) begin
            state <= ST_COPY;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_COPY: begin
          display[idx] <= src;
          idx          <= idx + 1'b1;
          if (idx == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign frame_cnt = cnt_r;
  assign regData   = ((ZERO_REG != 0) && (regAddr == '0)) ? '0 : display[regAddr];
endmodule

// File: tb/tb_vga_reg_shadow.sv
// Self-checking bench for vga_reg_shadow: reset vector table, directed corner
// sequences and randomized traffic against a snapshot-level reference model.
module tb_vga_reg_shadow;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_wa = '0;
  logic [31:0] cpu_wd = '0;
  logic        vsync = 1'b1;
  logic        freeze = 1'b0;
  logic [4:0]  regAddr = '0;
  logic [31:0] regData;
  logic        busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  vga_reg_shadow dut (
    .clk(clk), .resetn(resetn), .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .vsync(vsync), .freeze(freeze), .regAddr(regAddr), .regData(regData),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: snapshot semantics expressed per frame, not per copy slot.
  logic [31:0] mlive [32];
  logic [31:0] mdisp [32];
  logic [31:0] snap  [32];
  bit          copying;
  int          elapsed;
  logic [15:0] mcnt;
  logic        mvs_prev;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mlive[i] = '0; mdisp[i] = '0; snap[i] = '0; end
    copying = 0; elapsed = 0; mcnt = '0; mvs_prev = 1'b1;
  endtask

  // Called just before the clock edge with the inputs that edge will sample.
  task automatic model_edge();
    bit trig, wr_ok;
    trig  = (vsync == 1'b0) && (mvs_prev == 1'b1);
    wr_ok = cpu_we && (cpu_wa != 5'd0);
    mvs_prev = vsync;
    if (wr_ok) mlive[cpu_wa] = cpu_wd;
    if (copying) begin
      // A write lands in this frame's snapshot only if its register is not yet copied.
      if (wr_ok && (int'(cpu_wa) >= elapsed)) snap[cpu_wa] = cpu_wd;
      elapsed++;
      if (elapsed == 32) begin
        for (int i = 0; i < 32; i++) mdisp[i] = snap[i];
        mcnt++;
        copying = 0;
      end
    end else if (trig && !freeze) begin
      for (int i = 0; i < 32; i++) snap[i] = mlive[i];
      copying = 1; elapsed = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("busy", {31'd0, busy}, {31'd0, copying});
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, mcnt});
    if (!copying) chk("regData", regData, mdisp[regAddr]);
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; idle_inputs(); vsync = 1'b1; freeze = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct {
    logic        rn;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];
  int   nbusy;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 5'd0,  32'h0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd7,  32'h0, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 32'h0, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  32'h0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  32'h0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd3,  32'h0, 1'b0, 16'd0};
    vecs[6] = '{1'b1, 1'b1, 5'd31, 32'h13579BDF, 5'd31, 32'h0, 1'b0, 16'd0};
    vecs[7] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd16, 32'h0, 1'b0, 16'd0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      resetn = vecs[i].rn; cpu_we = vecs[i].we; cpu_wa = vecs[i].wa;
      cpu_wd = vecs[i].wd; regAddr = vecs[i].ra;
      @(posedge clk); #1;
      chk("vec_rd",   regData, vecs[i].exp_rd);
      chk("vec_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk("vec_cnt",  {16'd0, frame_cnt}, {16'd0, vecs[i].exp_cnt});
    end

    // Basic snapshot with exact busy length; also reg 0 write dropped.
    do_reset();
    cpu_we = 1'b1; cpu_wa = 5'd5; cpu_wd = 32'h12345678; step();
    cpu_wa = 5'd0; cpu_wd = 32'hFFFFFFFF; step();
    idle_inputs(); vsync = 1'b0; regAddr = 5'd5;
    step();
    nbusy = 0;
    while (busy && nbusy < 40) begin nbusy++; step(); end
    chk("busy_len", nbusy, 32);
    chk("snap_r5", regData, 32'h12345678);
    chk("snap_cnt", {16'd0, frame_cnt}, 32'd1);
    regAddr = 5'd0; #1;
    chk("zero_r0", regData, 32'h0);
    vsync = 1'b1; step();

    // Forwarding at idx 10 and deferral of reg 2 written at idx 20.
    cpu_we = 1'b1; cpu_wa = 5'd2; cpu_wd = 32'h22222222; step();
    idle_inputs(); vsync = 1'b0; step();
    for (int k = 0; k < 32; k++) begin
      idle_inputs();
      if (k == 10) begin cpu_we = 1'b1; cpu_wa = 5'd10; cpu_wd = 32'hA5A5A5A5; end
      if (k == 20) begin cpu_we = 1'b1; cpu_wa = 5'd2;  cpu_wd = 32'hBADC0DE0; end
      step();
    end
    idle_inputs(); vsync = 1'b1;
    regAddr = 5'd10; step();
    chk("fwd_r10", regData, 32'hA5A5A5A5);
    regAddr = 5'd2; #1;
    chk("defer_r2", regData, 32'h22222222);

    // Freeze at the edge: no copy; released: copy happens.
    freeze = 1'b1; vsync = 1'b0; step();
    chk("frz_busy", {31'd0, busy}, 32'd0);
    chk("frz_cnt", {16'd0, frame_cnt}, 32'd2);
    repeat (3) step();
    vsync = 1'b1; step();
    freeze = 1'b0; vsync = 1'b0; step();
    chk("unfrz_busy", {31'd0, busy}, 32'd1);
    repeat (32) step();
    chk("new_r2", regData, 32'hBADC0DE0);
    chk("unfrz_cnt", {16'd0, frame_cnt}, 32'd3);

    // vsync re-pulsed mid-copy is ignored.
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    repeat (5) step();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    repeat (30) step();
    chk("repulse_cnt", {16'd0, frame_cnt}, 32'd4);
    chk("repulse_busy", {31'd0, busy}, 32'd0);

    // Reset mid-copy at idx 15.
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    repeat (15) step();
    resetn = 1'b0; regAddr = 5'd5; #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_r5", regData, 32'h0);
    do_reset();
    vsync = 1'b0; step(); repeat (32) step();
    chk("rst_nostale_r5", regData, 32'h0);

    // Frame counter wrap.
    vsync = 1'b1; step();
    @(negedge clk);
    force dut.cnt_r = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt_r;
    mcnt = 16'hFFFF;
    step();
    chk("pre_wrap", {16'd0, frame_cnt}, 32'h0000FFFF);
    vsync = 1'b0; step(); repeat (32) step();
    chk("wrap_cnt", {16'd0, frame_cnt}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cpu_we  = ($urandom_range(0, 2) != 0);
      cpu_wa  = 5'($urandom_range(0, 31));
      cpu_wd  = $urandom;
      regAddr = 5'($urandom_range(0, 31));
      freeze  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) vsync = ~vsync;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_reg_shadow.md
Name: vga_reg_shadow

Overview:
Frame-synchronous shadow of the CPU register file that feeds the regData/regAddr lookup of the VGA debug screen. It tracks CPU register writes into a live bank continuously. At the start of each vertical sync it copies the live bank into a display bank, so a rendered frame never shows a mix of old and new register values. A freeze input holds the displayed snapshot for inspection.

Parameters:
REG_N, 32, number of shadowed registers (must equal 2**ADDR_W)
ADDR_W, 5, register address width
DATA_W, 32, register data width
ZERO_REG, 1, 1 = register 0 is hard-wired to zero; writes to it are dropped
VSYNC_POL, 0, active level of vsync (0 = active-low, 640x480 convention)

Ports:
clk  in  1  system clock, same domain as the VGA core
resetn  in  1  asynchronous, active-low reset
cpu_we  in  1  CPU register-file write enable
cpu_wa  in  ADDR_W  CPU write address
cpu_wd  in  DATA_W  CPU write data
vsync  in  1  vsync from the VGA core (same clock domain)
freeze  in  1  1 = suppress snapshot updates
regAddr  in  ADDR_W  register index requested by the VGA core
regData  out  DATA_W  display-bank contents at regAddr
busy  out  1  copy in progress
frame_cnt  out  16  number of completed snapshots

Behaviour:
- Reset (async, resetn=0): live and display banks all zero, state IDLE, copy index 0, busy=0, frame_cnt=0, vsync history register = inactive level.
- Live write: on clk, if cpu_we and not (ZERO_REG and cpu_wa==0), then live[cpu_wa] <= cpu_wd. The write is accepted in every state.
- Read path: regData = display[regAddr], combinational, 0-cycle latency. With ZERO_REG, index 0 always reads 0.
- Trigger: vsync is registered once (vs_q). trig = (vsync==VSYNC_POL) and (vs_q!=VSYNC_POL), i.e. the assertion edge.
- FSM, two states:
  - IDLE: if trig and !freeze, go to COPY with idx=0 and busy=1. If trig and freeze, stay in IDLE; no copy and no count.
  - COPY: each cycle display[idx] <= src, where src = cpu_wd if (cpu_we and cpu_wa==idx and write not dropped), else live[idx] (write forwarding). idx increments each cycle. After idx==REG_N-1 is copied, return to IDLE, busy=0, frame_cnt += 1 (wraps 0xFFFF -> 0).
- Copy latency: exactly REG_N cycles (32). busy is high for exactly those cycles, starting the cycle after the trig edge.
- A trig that occurs during COPY is ignored; there is no queuing.
- freeze is sampled only at trig. Asserting freeze mid-COPY does not abort the copy.
- Writes to live[idx'] for an idx' already copied are deferred to the next snapshot.
- Display bank changes only during COPY. Because the trigger is vsync, updates fall in vertical blanking.
- Reset asserted mid-COPY returns everything to reset values immediately; there is no partial snapshot retained.

Decomposition:
- Package vga_dbg_pkg:
  - state enum (ST_IDLE, ST_COPY)
  - constants DBG_REG_N=32, DBG_ADDR_W=5, DBG_DATA_W=32
- Sub-module vga_sync_edge: a one-flop edge detector parameterised by polarity, producing trig. It is reusable for hsync.
- Banks are flop arrays; REG_N x DATA_W is small enough that no RAM inference is needed.

Test Plan:
- Reset values: hold resetn=0 and poke regAddr 0..31 -> regData=0, busy=0, frame_cnt=0. Write live[3]=0xDEADBEEF with no vsync -> regData@3 stays 0.
- Basic snapshot: write live[5]=0x12345678, then drive vsync 1->0 -> busy high for exactly 32 cycles starting 1 cycle after the edge. Afterwards regData@5=0x12345678 and frame_cnt=1.
- ZERO_REG: write cpu_wa=0 with 0xFFFFFFFF, then snapshot -> regData@0=0 and the live write is dropped.
- Forwarding and deferral:
  - During COPY, write reg 10 in the exact cycle idx==10 with 0xA5A5A5A5 -> display[10]=0xA5A5A5A5.
  - Write reg 2 when idx==20 -> display[2] keeps its old value until the next snapshot.
- Freeze: freeze=1 at the vsync edge -> no busy, frame_cnt unchanged, display unchanged. Release freeze, next edge -> copy occurs and frame_cnt increments.
- Robustness:
  - Pulse vsync again mid-COPY -> ignored, exactly one count.
  - Assert resetn=0 at idx==15 -> all outputs zero and no stale data.
  - Preload frame_cnt to 0xFFFF via 65535 frames (or force) -> the next snapshot wraps it to 0.
